bcd_display_scanner: RTL and testbench

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

---
 rtl/bcd_display_scanner.sv | 96 +++++++++
 tb/tb_bcd_display_scanner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexes four BCD digits onto a shared 7-segment bus.
// Digits are captured on update into a shadow register and scanned PRESCALE cycles each.
module bcd_display_scanner #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        update,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_sel,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic        invalid
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [15:0]   shadow_q;
    logic [3:0]    dp_shadow_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic          frame_done_q;

    logic          wrap;
    logic [3:0]    nib;
    logic [3:0]    lz;
    logic [6:0]    glyph;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;

    always_comb begin
        wrap  = cnt_q == LAST;
        nib   = shadow_q[{idx_q, 2'b00} +: 4];
        // lz[k]: nibble k and everything above it are zero; digit 0 is never blanked
        lz[3] = shadow_q[15:12] == 4'd0;
        lz[2] = lz[3] && shadow_q[11:8] == 4'd0;
        lz[1] = lz[2] && shadow_q[7:4] == 4'd0;
        lz[0] = 1'b0;
        case (nib)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h40;
        endcase
        an_d  = 4'b0001 << idx_q;
        seg_d = (blank_lz && lz[idx_q]) ? 7'h00 : glyph;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q     <= '0;
            dp_shadow_q  <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            an_q         <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (update) begin
                shadow_q    <= digits_in;
                dp_shadow_q <= dp_sel;
            end
            if (enable) begin
                cnt_q <= wrap ? '0 : cnt_q + 1'b1;
                if (wrap)
                    idx_q <= idx_q + 2'd1;
            end
            an_q         <= enable ? an_d : 4'b0000;
            seg_q        <= enable ? seg_d : 7'h00;
            dp_q         <= enable && dp_shadow_q[idx_q];
            frame_done_q <= enable && wrap && idx_q == 2'd3;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign invalid    = (shadow_q[3:0] > 4'd9) || (shadow_q[7:4] > 4'd9) ||
                        (shadow_q[11:8] > 4'd9) || (shadow_q[15:12] > 4'd9);
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed scenarios with a cycle-stamped scoreboard.
// Stimulus pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_bcd_display_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        update = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_sel = 4'b0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  an, an1;
    logic [6:0]  seg, seg1;
    logic        dp, dp1, frame_done, frame_done1, invalid, invalid1;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        bit          sel;
        logic [13:0] v;
    } exp_t;
    exp_t sb[$];

    bcd_display_scanner #(.PRESCALE(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .update(update),
        .digits_in(digits_in), .dp_sel(dp_sel), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done), .invalid(invalid)
    );

    bcd_display_scanner #(.PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .update(update),
        .digits_in(digits_in), .dp_sel(dp_sel), .blank_lz(blank_lz),
        .an(an1), .seg(seg1), .dp(dp1), .frame_done(frame_done1), .invalid(invalid1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sorted insert so entries for both instances interleave by cycle
    task automatic push(input int c, input bit s, input logic [3:0] a, input logic [6:0] sg,
                        input logic d, input logic f, input logic iv);
        exp_t e;
        int   i;
        e.cyc = c;
        e.sel = s;
        e.v   = {a, sg, d, f, iv};
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endtask

    task automatic run(input int c, input int n, input logic [3:0] a, input logic [6:0] sg,
                       input logic d, input logic iv, input logic f_last);
        for (int i = 0; i < n; i++)
            push(c + i, 1'b0, a, sg, d, f_last && (i == n - 1), iv);
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [13:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = e.sel ? {an1, seg1, dp1, frame_done1, invalid1} : {an, seg, dp, frame_done, invalid};
            n_chk++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL missed dut%0d entry for cycle %0d, checked at cycle %0d", e.sel, e.cyc, cyc);
            end else if (act !== e.v) begin
                n_fail++;
                $display("FAIL out dut%0d cycle %0d: got an=%b seg=%h dp=%b fd=%b inv=%b, want an=%b seg=%h dp=%b fd=%b inv=%b",
                         e.sel, cyc, act[13:10], act[9:3], act[2], act[1], act[0],
                         e.v[13:10], e.v[9:3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    initial begin
        push(1, 1'b0, 4'b0000, 7'h00, 1'b0, 1'b0, 1'b0);
        push(2, 1'b0, 4'b0000, 7'h00, 1'b0, 1'b0, 1'b0);
        // Scan order with 16'h4321, dp on digit3
        goto(2);
        reset = 1'b0; enable = 1'b1; update = 1'b1; digits_in = 16'h4321; dp_sel = 4'b1000;
        push(3, 1'b0, 4'b0001, 7'h3F, 1'b0, 1'b0, 1'b0);
        run(4, 3, 4'b0001, 7'h06, 1'b0, 1'b0, 1'b0);
        run(7, 4, 4'b0010, 7'h5B, 1'b0, 1'b0, 1'b0);
        run(11, 4, 4'b0100, 7'h4F, 1'b0, 1'b0, 1'b0);
        run(15, 4, 4'b1000, 7'h66, 1'b1, 1'b0, 1'b1);
        run(19, 4, 4'b0001, 7'h06, 1'b0, 1'b0, 1'b0);
        run(23, 4, 4'b0010, 7'h5B, 1'b0, 1'b0, 1'b0);
        run(27, 4, 4'b0100, 7'h4F, 1'b0, 1'b0, 1'b0);
        run(31, 4, 4'b1000, 7'h66, 1'b1, 1'b0, 1'b1);
        goto(3);
        update = 1'b0;
        // Leading-zero blanking with 16'h0070, dp on blanked digit2
        goto(34);
        update = 1'b1; digits_in = 16'h0070; dp_sel = 4'b0100; blank_lz = 1'b1;
        push(35, 1'b0, 4'b0001, 7'h06, 1'b0, 1'b0, 1'b0);
        run(36, 3, 4'b0001, 7'h3F, 1'b0, 1'b0, 1'b0);
        run(39, 4, 4'b0010, 7'h07, 1'b0, 1'b0, 1'b0);
        run(43, 4, 4'b0100, 7'h00, 1'b1, 1'b0, 1'b0);
        run(47, 4, 4'b1000, 7'h00, 1'b0, 1'b0, 1'b1);
        run(51, 4, 4'b0001, 7'h3F, 1'b0, 1'b0, 1'b0);
        run(55, 4, 4'b0010, 7'h07, 1'b0, 1'b0, 1'b0);
        run(59, 4, 4'b0100, 7'h3F, 1'b1, 1'b0, 1'b0);
        run(63, 4, 4'b1000, 7'h3F, 1'b0, 1'b0, 1'b1);
        goto(35);
        update = 1'b0;
        goto(50);
        blank_lz = 1'b0;
        // Invalid nibble, then cleared mid-digit1
        goto(66);
        update = 1'b1; digits_in = 16'h00A5; dp_sel = 4'b0000;
        push(67, 1'b0, 4'b0001, 7'h3F, 1'b0, 1'b0, 1'b1);
        run(68, 3, 4'b0001, 7'h6D, 1'b0, 1'b1, 1'b0);
        run(71, 2, 4'b0010, 7'h40, 1'b0, 1'b1, 1'b0);
        push(73, 1'b0, 4'b0010, 7'h40, 1'b0, 1'b0, 1'b0);
        push(74, 1'b0, 4'b0010, 7'h3F, 1'b0, 1'b0, 1'b0);
        run(75, 4, 4'b0100, 7'h3F, 1'b0, 1'b0, 1'b0);
        run(79, 4, 4'b1000, 7'h3F, 1'b0, 1'b0, 1'b1);
        goto(67);
        update = 1'b0;
        goto(72);
        update = 1'b1; digits_in = 16'h0005;
        goto(73);
        update = 1'b0;
        // Freeze mid-digit2, update while frozen, resume for the remaining count
        goto(82);
        run(83, 4, 4'b0001, 7'h6D, 1'b0, 1'b0, 1'b0);
        run(87, 4, 4'b0010, 7'h3F, 1'b0, 1'b0, 1'b0);
        run(91, 2, 4'b0100, 7'h3F, 1'b0, 1'b0, 1'b0);
        run(93, 3, 4'b0000, 7'h00, 1'b0, 1'b0, 1'b0);
        run(96, 2, 4'b0100, 7'h7F, 1'b1, 1'b0, 1'b0);
        run(98, 4, 4'b1000, 7'h3F, 1'b0, 1'b0, 1'b1);
        goto(92);
        enable = 1'b0;
        goto(93);
        update = 1'b1; digits_in = 16'h0800; dp_sel = 4'b0100;
        goto(94);
        update = 1'b0; digits_in = 16'h9999; dp_sel = 4'b1111;
        goto(95);
        enable = 1'b1;
        // Async reset while digit2 is lit, with a concurrent update that must be ignored
        goto(101);
        run(102, 4, 4'b0001, 7'h3F, 1'b0, 1'b0, 1'b0);
        run(106, 4, 4'b0010, 7'h3F, 1'b0, 1'b0, 1'b0);
        push(110, 1'b0, 4'b0100, 7'h7F, 1'b1, 1'b0, 1'b0);
        run(111, 2, 4'b0000, 7'h00, 1'b0, 1'b0, 1'b0);
        run(113, 4, 4'b0001, 7'h3F, 1'b0, 1'b0, 1'b0);
        run(117, 4, 4'b0010, 7'h3F, 1'b0, 1'b0, 1'b0);
        // PRESCALE=1 instance: rotates every cycle, dp only on digit2 once loaded
        for (int s = 113; s <= 129; s++) begin
            int k;
            k = (s - 113) % 4;
            push(s, 1'b1, 4'(1 << k), 7'h3F, s >= 122 && k == 2, k == 3, 1'b0);
        end
        goto(111);
        reset = 1'b1; update = 1'b1; digits_in = 16'h1234;
        goto(112);
        reset = 1'b0; update = 1'b0;
        goto(120);
        update = 1'b1; digits_in = 16'h0000; dp_sel = 4'b0100;
        goto(121);
        update = 1'b0;
        goto(132);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL pending: %0d expected entries never checked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
